// File: rtl/ram_port_master.sv
// Initiator for one synchronous RAM port: arbitrates clear engine > video > CPU
// and returns read data through a two-stage tag pipeline matching the RAM latency.
module ram_port_master #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 9,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_valid,
    output logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // Travels alongside each issued operation until its response is due.
    typedef struct packed {
        logic valid;
        logic cpu;
        logic read;
    } tag_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  cpu_pending;
    logic                  issue_clear, issue_vid, issue_cpu;
    tag_t                  tag1, tag2, tag1_next;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (clear_start)     next_state = S_CLEAR;
            S_CLEAR: if (clear_cnt == '1) next_state = S_IDLE;
            default:                      next_state = S_IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state == S_CLEAR);
    end

    // Same-edge priority: a CPU request that loses simply retries next cycle.
    always_comb begin
        issue_clear = clear_busy;
        issue_vid   = !clear_busy && vid_req;
        issue_cpu   = !clear_busy && !vid_req && cpu_req && !cpu_pending;
        tag1_next   = '0;
        if (issue_vid) begin
            tag1_next = '{valid: 1'b1, cpu: 1'b0, read: 1'b1};
        end else if (issue_cpu) begin
            tag1_next = '{valid: 1'b1, cpu: 1'b1, read: !cpu_we};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            clear_cnt   <= '0;
            cpu_pending <= 1'b0;
            tag1        <= '0;
            tag2        <= '0;
            vid_valid   <= 1'b0;
            vid_data    <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            ram_wren <= issue_clear || (issue_cpu && cpu_we);
            if (issue_clear) begin
                ram_address <= clear_cnt;
                ram_data    <= CLEAR_VALUE;
                clear_cnt   <= clear_cnt + 1'b1;
            end else if (issue_vid) begin
                ram_address <= vid_addr;
            end else if (issue_cpu) begin
                ram_address <= cpu_addr;
                ram_data    <= cpu_wdata;
                cpu_pending <= 1'b1;
            end

            tag1 <= tag1_next;
            tag2 <= tag1;

            // Writes complete once the RAM has sampled them; reads wait for ram_q.
            vid_valid <= tag2.valid && !tag2.cpu;
            if (tag2.valid && !tag2.cpu) vid_data <= ram_q;

            cpu_ack <= (tag1.valid && tag1.cpu && !tag1.read) ||
                       (tag2.valid && tag2.cpu && tag2.read);
            if (tag2.valid && tag2.cpu && tag2.read) cpu_rdata <= ram_q;

            // Released on the edge raising cpu_ack, so the next edge samples cpu_req again.
            if ((tag1.valid && tag1.cpu && !tag1.read) ||
                (tag2.valid && tag2.cpu && tag2.read)) begin
                cpu_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ram_port_master.md
Name: ram_port_master

Overview:
- Initiator side of a single synchronous RAM port: registered address/data/write-enable out, one-cycle-latency registered read data back.
- Arbitrates three sources onto the port: a hardware clear engine, a video fetch stream and a CPU request/acknowledge port.
- Pipelined, so one RAM operation can issue per cycle.
- Sits between CPU/video logic and one port of a playfield/sprite dual-port RAM.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 9, RAM address width. Depth = 2**ADDR_WIDTH.
- CLEAR_VALUE, 0, word written by the clear engine.
- CLEAR_ON_RESET, 1, when 1 the clear engine starts automatically on reset release.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_start  in  1  one-cycle pulse that requests a full RAM clear.
- clear_busy  out  1  high while the clear engine owns the port.
- vid_req  in  1  video read strobe; no backpressure.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_valid  out  1  one-cycle pulse marking vid_data as valid.
- vid_data  out  DATA_WIDTH  video read data.
- cpu_req  in  1  CPU request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  CPU read data, valid with cpu_ack on reads.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM write data.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  DATA_WIDTH  from RAM registered read data.

Behaviour:
- Reset:
  - All outputs 0, except clear_busy = CLEAR_ON_RESET.
  - Clear counter 0; pipeline tags cleared.
  - In-flight operations are discarded: no vid_valid or cpu_ack is ever produced for them.
- Issue, edge E0:
  - Priority: clear > video > CPU.
  - The winner's address, data and wren are registered onto ram_*.
  - With no winner: ram_wren = 0; ram_address holds its last value.
- Read pipeline:
  - Tag stage 1 {source, is_read} is valid in the cycle after E0. The RAM samples at E1.
  - At E1, tag stage 1 moves to tag stage 2.
  - At E2, the master captures ram_q into vid_data or cpu_rdata and pulses vid_valid or cpu_ack.
  - Read latency: request cycle c0, response high in c3.
- CPU write: cpu_ack pulses in c2, once the write has been sampled by the RAM at E1.
- Back-to-back issue is allowed every cycle. Responses return in issue order.
- CPU handshake:
  - At most one CPU operation is outstanding. cpu_req is not sampled while one is in flight, including the edge that raises cpu_ack.
  - The requester keeps cpu_req, cpu_we, cpu_addr and cpu_wdata stable until cpu_ack.
  - cpu_req still high at the edge ending the ack cycle is a new transaction.
  - The CPU may be stalled indefinitely by video or clear.
- Video:
  - vid_req is accepted on every cycle it is high, unless the clear engine owns the port.
  - vid_req during clear_busy is dropped and produces no vid_valid.
- Clear engine:
  - clear_start is honoured only when clear_busy = 0; clear_busy rises in the next cycle.
  - Issues writes at addresses 0 .. Depth-1, one per cycle, data CLEAR_VALUE.
  - clear_busy falls at the edge that issues the last address, so it is high for exactly Depth cycles.
  - Reads issued before the clear started drain and respond normally.
  - clear_start while clear_busy = 1 is ignored.
  - The counter wraps to 0 on completion.
- Simultaneous events:
  - Issue decisions use same-edge inputs; a pending CPU request loses to vid_req and retries every cycle.
  - clear_start and vid_req in the same cycle: video issues; clear begins next cycle.

Test Plan:
- Reset release with CLEAR_ON_RESET = 1, ADDR_WIDTH = 9, cpu_req held high -> ram_wren = 1 for 512 consecutive cycles, addresses 0x000..0x1FF, data 0x00; clear_busy high for exactly 512 cycles; cpu_ack only after clear_busy falls.
- CPU write 0x05A <= 0x3C, then CPU read 0x05A -> write ack 2 cycles after the request cycle; read ack 3 cycles after its accept; cpu_rdata = 0x3C.
- vid_req on 3 consecutive cycles at 0x010, 0x011, 0x012 (RAM preloaded with 0xA1, 0xA2, 0xA3) -> vid_valid high for 3 consecutive cycles starting 3 cycles after the first request; vid_data = 0xA1, 0xA2, 0xA3.
- vid_req and cpu_req (read 0x020) in the same cycle -> video issues at E0, CPU at E1; vid_valid in c3, cpu_ack in c4, both with correct data.
- reset_n low for one cycle while a CPU read and a video read are in flight -> no cpu_ack or vid_valid afterwards; all outputs 0 during reset.
- clear_start pulsed during an active clear, plus vid_req during the clear -> clear length stays 512 cycles; no vid_valid for the dropped requests.
